// File: rtl/rob_retire_ctrl.sv
// In-order ROB retirement controller: up to 3 entries per cycle, store commit handshake, mispredict squash.
// Optional RETIRE_PERF_CNT_EN adds a 32-bit retired-instruction counter output.
`ifndef PR
`define PR 6
`endif

module rob_retire_ctrl (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            head_valid,
  input  logic [2:0]            head_completed,
  input  logic [2:0]            head_is_store,
  input  logic [2:0]            head_mispred,
  input  logic [2:0][`PR-1:0]   head_Tnew,
  input  logic [2:0][`PR-1:0]   head_Told,
  input  logic [2:0][4:0]       head_arch_reg,
  input  logic                  st_commit_ack,
  output logic [1:0]            retire_num,
  output logic [2:0]            retire_valid,
  output logic [2:0]            amt_wr_en,
  output logic [2:0][4:0]       amt_wr_idx,
  output logic [2:0][`PR-1:0]   amt_wr_tag,
  output logic [2:0]            free_en,
  output logic [2:0][`PR-1:0]   free_tag,
  output logic                  st_commit_req,
  output logic                  squash
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]           retired_count
`endif
);

  typedef enum logic [1:0] {
    RUN,
    STORE_WAIT,
    SQUASH
  } state_t;

  state_t state, state_next;

  logic can_retire;
  logic store_ok;
  logic alive;
  logic store_hit;
  logic mispred_hit;

  // Retire chain: stops at the first blocked way, unacknowledged store or mispredict.
  always_comb begin
    retire_valid = '0;
    store_hit    = 1'b0;
    mispred_hit  = 1'b0;
    alive        = 1'b1;
    can_retire   = 1'b0;
    store_ok     = 1'b0;
    case (state)
      RUN:        can_retire = 1'b1;
      STORE_WAIT: begin
        can_retire = st_commit_ack;
        store_ok   = st_commit_ack;
      end
      default:    can_retire = 1'b0;
    endcase
    for (int unsigned i = 0; i < 3; i++) begin
      if (alive && can_retire) begin
        if (!(head_valid[i] && head_completed[i])) begin
          alive = 1'b0;
        end else if (head_is_store[i] && !(i == 0 && store_ok)) begin
          store_hit = 1'b1;
          alive     = 1'b0;
        end else begin
          retire_valid[i] = 1'b1;
          if (head_mispred[i]) begin
            mispred_hit = 1'b1;
            alive       = 1'b0;
          end
        end
      end
    end
    if (reset) begin
      retire_valid = '0;
      store_hit    = 1'b0;
      mispred_hit  = 1'b0;
    end
  end

  always_comb begin
    retire_num = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]} + {1'b0, retire_valid[2]};
    amt_wr_idx = head_arch_reg;
    amt_wr_tag = head_Tnew;
    free_tag   = head_Told;
    amt_wr_en  = '0;
    free_en    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      amt_wr_en[i] = retire_valid[i] && (head_arch_reg[i] != '0);
      free_en[i]   = retire_valid[i];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN, STORE_WAIT: begin
        if (state == STORE_WAIT && !st_commit_ack)
          state_next = STORE_WAIT;
        else if (mispred_hit)
          state_next = SQUASH;
        else if (store_hit)
          state_next = STORE_WAIT;
        else
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Request/flush are registered copies of the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      st_commit_req <= 1'b0;
      squash        <= 1'b0;
    end else begin
      state         <= state_next;
      st_commit_req <= (state_next == STORE_WAIT);
      squash        <= (state_next == SQUASH);
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      retired_count <= '0;
    else
      retired_count <= retired_count + {30'd0, retire_num};
  end
`endif

endmodule
